// File: rtl/ula_pkg.sv
// Shared definitions for the ula registered ALU: the opcode encoding and the default width.
package ula_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

endpackage

// File: rtl/ula_comb.sv
// Combinational core of ula: next result and status flag from a, b and op.
// Defining ULA_SAT_EN makes ADD/SUB saturate instead of wrapping.
module ula_comb
  import ula_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] s_next,
  output logic             flag_next
);

  // Carry and borrow both land in bit WIDTH of the widened unsigned result.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    s_next    = '0;
    flag_next = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        flag_next = sum[WIDTH];
`ifdef ULA_SAT_EN
        s_next = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        s_next = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        flag_next = diff[WIDTH];
`ifdef ULA_SAT_EN
        s_next = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        s_next = diff[WIDTH-1:0];
`endif
      end
      OP_AND: begin
        s_next    = a & b;
        flag_next = (s_next == '0);
      end
      OP_OR: begin
        s_next    = a | b;
        flag_next = (s_next == '0);
      end
      OP_XOR: begin
        s_next    = a ^ b;
        flag_next = (s_next == '0);
      end
      OP_NOT: begin
        s_next    = ~a;
        flag_next = (s_next == '0);
      end
      OP_SHL: begin
        s_next    = {a[WIDTH-2:0], 1'b0};
        flag_next = a[WIDTH-1];
      end
      OP_SHR: begin
        s_next    = {1'b0, a[WIDTH-1:1]};
        flag_next = a[0];
      end
    endcase
  end

endmodule

// File: rtl/ula.sv
// Registered ALU top: ula_comb feeding the s/flag output registers (1-cycle latency).
// Build option: define ULA_SAT_EN for saturating ADD/SUB.
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] s,
  output logic             flag
);

  logic [WIDTH-1:0] s_next;
  logic             flag_next;

  ula_comb #(.WIDTH(WIDTH)) u_comb (
    .a         (a),
    .b         (b),
    .op        (op),
    .s_next    (s_next),
    .flag_next (flag_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      flag <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep register updates race-free across always_ff blocks.
      s    <= s_next;
      flag <= flag_next;
    end
  end

endmodule

// File: tb/tb_ula.sv
// Directed self-checking bench for ula; expected values follow ULA_SAT_EN when it is defined.
module tb_ula;
  import ula_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic [W-1:0] s;
  logic         flag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ula #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .s     (s),
    .flag  (flag)
  );

  // Values are compared as {flag, s}.
  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got flag=%b s=%h, expected flag=%b s=%h",
               tag, got[W], got[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic ef, input logic [W-1:0] es);
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #1 check(tag, {flag, s}, {ef, es});
  endtask

  // Back-to-back sequence: a new vector every cycle.
  logic [2:0]   bb_op [6];
  logic [W-1:0] bb_a  [6];
  logic [W-1:0] bb_b  [6];
  logic [W:0]   bb_exp[6];

  initial begin
    rst_n = 1'b0;
    op    = OP_ADD;
    a     = 8'h12;
    b     = 8'h34;
    #1 check("reset_initial", {flag, s}, 9'h000);
    repeat (3) @(posedge clk);
    #1 check("reset_held_clocked", {flag, s}, 9'h000);

    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_hold", {flag, s}, 9'h000);

`ifdef ULA_SAT_EN
    step("sub_underflow", OP_SUB, 8'h00, 8'h04, 1'b1, 8'h00);
    step("add_overflow",  OP_ADD, 8'hFF, 8'h01, 1'b1, 8'hFF);
    step("add_80_80",     OP_ADD, 8'h80, 8'h80, 1'b1, 8'hFF);
`else
    step("sub_underflow", OP_SUB, 8'h00, 8'h04, 1'b1, 8'hFC);
    step("add_overflow",  OP_ADD, 8'hFF, 8'h01, 1'b1, 8'h00);
    step("add_80_80",     OP_ADD, 8'h80, 8'h80, 1'b1, 8'h00);
`endif
    step("sub_plain",     OP_SUB, 8'h09, 8'h04, 1'b0, 8'h05);
    step("sub_equal",     OP_SUB, 8'h04, 8'h04, 1'b0, 8'h00);
    step("add_plain",     OP_ADD, 8'h12, 8'h34, 1'b0, 8'h46);
    step("and_zero",      OP_AND, 8'hF0, 8'h0F, 1'b1, 8'h00);
    step("or_ff",         OP_OR,  8'hF0, 8'h0F, 1'b0, 8'hFF);
    step("xor_aa_ff",     OP_XOR, 8'hAA, 8'hFF, 1'b0, 8'h55);
    step("not_ff",        OP_NOT, 8'hFF, 8'h5A, 1'b1, 8'h00);
    step("not_00",        OP_NOT, 8'h00, 8'hFF, 1'b0, 8'hFF);
    step("shl_81",        OP_SHL, 8'h81, 8'h00, 1'b1, 8'h02);
    step("shr_81",        OP_SHR, 8'h81, 8'h00, 1'b1, 8'h40);
    step("shr_02",        OP_SHR, 8'h02, 8'h00, 1'b0, 8'h01);

    bb_op[0] = OP_ADD; bb_a[0] = 8'h01; bb_b[0] = 8'h02; bb_exp[0] = {1'b0, 8'h03};
    bb_op[1] = OP_XOR; bb_a[1] = 8'h0F; bb_b[1] = 8'h01; bb_exp[1] = {1'b0, 8'h0E};
    bb_op[2] = OP_SHL; bb_a[2] = 8'h40; bb_b[2] = 8'h00; bb_exp[2] = {1'b0, 8'h80};
    bb_op[3] = OP_SUB; bb_a[3] = 8'h10; bb_b[3] = 8'h01; bb_exp[3] = {1'b0, 8'h0F};
    bb_op[4] = OP_OR;  bb_a[4] = 8'h00; bb_b[4] = 8'h00; bb_exp[4] = {1'b1, 8'h00};
    bb_op[5] = OP_SHR; bb_a[5] = 8'h01; bb_b[5] = 8'h00; bb_exp[5] = {1'b1, 8'h00};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      op = bb_op[i];
      a  = bb_a[i];
      b  = bb_b[i];
      // Outputs must not follow the new inputs before the next edge.
      #1 if (i > 0) check("b2b_hold", {flag, s}, bb_exp[i-1]);
      @(posedge clk);
      #1 check("b2b_result", {flag, s}, bb_exp[i]);
    end

    step("pre_reset_add", OP_ADD, 8'h12, 8'h34, 1'b0, 8'h46);
    #1 rst_n = 1'b0;
    #1 check("reset_async_midcycle", {flag, s}, 9'h000);
    @(posedge clk);
    #1 check("reset_async_held", {flag, s}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_async_release", {flag, s}, 9'h000);
    @(posedge clk);
    #1 check("after_reset_first_edge", {flag, s}, {1'b0, 8'h46});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ula.md
Name: ula

Overview:
- Registered arithmetic/logic unit: two WIDTH-bit operands, 3-bit opcode.
- Produces a WIDTH-bit result and a 1-bit status flag, both registered on the rising clock edge.
- Single-cycle datapath building block.
- Fully synchronous except for the asynchronous active-low reset.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range ≥ 2).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select
- s  output  WIDTH  registered result
- flag  output  1  registered status flag (meaning per op, below)

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n low forces s = 0 and flag = 0 immediately, regardless of clk.
- Outputs hold 0 until the first rising edge after rst_n deasserts.
- Latency is 1 cycle: a, b and op are sampled on each rising edge, and s/flag show the result after that edge.
- There is no enable; a new result is computed every cycle.
- Outputs never change combinationally with inputs.
- Opcode map (s; flag):
  - 000 ADD: s = a+b mod 2^WIDTH; flag = carry out.
  - 001 SUB: s = a−b mod 2^WIDTH (two's complement); flag = borrow (1 when a < b unsigned).
  - 010 AND: s = a&b; flag = (s == 0).
  - 011 OR: s = a|b; flag = (s == 0).
  - 100 XOR: s = a^b; flag = (s == 0).
  - 101 NOT: s = ~a (b ignored); flag = (s == 0).
  - 110 SHL: s = a<<1, LSB filled with 0; flag = a[WIDTH−1] (bit shifted out).
  - 111 SHR: s = a>>1 logical, MSB filled with 0; flag = a[0].
- Arithmetic is unsigned; the carry/borrow is computed over WIDTH+1 bits.
- Wrap-around: 0xFF+0x01 → s = 0x00, flag = 1; 0x00−0x01 → s = 0xFF, flag = 1.
- Reset asserted mid-operation discards the pending result; there is no residual state beyond the s/flag registers.
- Inputs containing X/Z: behaviour undefined; the bench must drive known values.

Optional Feature:
- Macro ULA_SAT_EN.
- When defined, ADD and SUB saturate:
  - ADD overflow gives s = all ones, flag = 1.
  - SUB underflow gives s = 0, flag = 1.
- When undefined, ADD/SUB wrap modulo 2^WIDTH as above.
- All other opcodes are identical in both builds.

Decomposition:
- Package ula_pkg holds:
  - the 3-bit opcode typedef/enum (OP_ADD … OP_SHR, values 000–111);
  - the default-width constant.
- One natural sub-module, ula_comb: purely combinational, computes the next s and flag from a, b and op (including the ULA_SAT_EN logic).
- The top module ula holds only the output registers and reset.

Test Plan:
- Reset: hold rst_n = 0 and toggle clk → s = 0x00, flag = 0. Assert rst_n asynchronously between edges → outputs clear immediately.
- SUB: op = 001, a = 0x00, b = 0x04 → after one edge, s = 0xFC, flag = 1 (with ULA_SAT_EN: s = 0x00, flag = 1). Also a = 0x09, b = 0x04 → s = 0x05, flag = 0.
- ADD: a = 0xFF, b = 0x01 → s = 0x00, flag = 1 (with ULA_SAT_EN: s = 0xFF, flag = 1). Also a = 0x12, b = 0x34 → s = 0x46, flag = 0.
- Logic: AND 0xF0 & 0x0F → s = 0x00, flag = 1. OR → s = 0xFF, flag = 0. XOR 0xAA ^ 0xFF → s = 0x55, flag = 0. NOT 0xFF → s = 0x00, flag = 1.
- Shifts: SHL a = 0x81 → s = 0x02, flag = 1. SHR a = 0x81 → s = 0x40, flag = 1. SHR a = 0x02 → s = 0x01, flag = 0.
- Latency: change op/a/b every cycle with a back-to-back sequence → each result appears exactly one edge later, with no bubbles and no combinational glitches on s.
